// File: rtl/hit_edge_detect_pkg.sv
// Shared state encoding, edge-bit positions and default player dimensions for hit_edge_detect.
// The saturating counter helper only exists when HIT_EDGE_COUNT_EN is defined.
package hit_edge_pkg;

   typedef enum logic [1:0] {
      INITIAL_ST,
      WAIT_SOF_ST,
      ACCUM_ST
   } state_t;

   localparam int LEFT   = 3;
   localparam int TOP    = 2;
   localparam int RIGHT  = 1;
   localparam int BOTTOM = 0;

   localparam int DEFAULT_OBJECT_WIDTH_X = 64;
   localparam int DEFAULT_OBJECT_HIGHT_Y = 64;
   localparam int DEFAULT_EDGE_MARGIN    = 8;

`ifdef HIT_EDGE_COUNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] count, input logic inc);
      if (inc && (count != 16'hFFFF)) begin
         return count + 16'd1;
      end
      return count;
   endfunction
`endif

endpackage

// File: rtl/hit_edge_detect_if.sv
// Pixel stream in, per-frame hit summary out. hitCount is present only with HIT_EDGE_COUNT_EN.
interface hit_edge_detect_if;

   logic               startOfFrame;
   logic [10:0]        pixelX;
   logic [10:0]        pixelY;
   logic               playerDR;
   logic               obstacleDR;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic               collision;
   logic [3:0]         HitEdgeCode;

`ifdef HIT_EDGE_COUNT_EN
   logic [15:0]        hitCount;

   modport master (
      output startOfFrame, pixelX, pixelY, playerDR, obstacleDR, topLeftX, topLeftY,
      input  collision, HitEdgeCode, hitCount
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, playerDR, obstacleDR, topLeftX, topLeftY,
      output collision, HitEdgeCode, hitCount
   );
`else
   modport master (
      output startOfFrame, pixelX, pixelY, playerDR, obstacleDR, topLeftX, topLeftY,
      input  collision, HitEdgeCode
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, playerDR, obstacleDR, topLeftX, topLeftY,
      output collision, HitEdgeCode
   );
`endif

endinterface

// File: rtl/hit_edge_detect_classify.sv
// Combinational offset of the current pixel from the player corner and edge-zone classification.
module edge_zone_classify
   import hit_edge_pkg::*;
#(
   parameter int OBJECT_WIDTH_X = DEFAULT_OBJECT_WIDTH_X,
   parameter int OBJECT_HIGHT_Y = DEFAULT_OBJECT_HIGHT_Y,
   parameter int EDGE_MARGIN    = DEFAULT_EDGE_MARGIN
)(
   input  logic [10:0]        pixel_x,
   input  logic [10:0]        pixel_y,
   input  logic signed [10:0] corner_x,
   input  logic signed [10:0] corner_y,
   output logic [3:0]         edge_bits
);

   logic signed [11:0] off_x;
   logic signed [11:0] off_y;
   int                 ox;
   int                 oy;
   logic               in_box;

   // Corner is sign-extended so players partly off the left/top of the screen still classify correctly.
   assign off_x = $signed({1'b0, pixel_x}) - $signed({corner_x[10], corner_x});
   assign off_y = $signed({1'b0, pixel_y}) - $signed({corner_y[10], corner_y});
   assign ox    = int'(off_x);
   assign oy    = int'(off_y);

   always_comb begin
      edge_bits = 4'b0000;
      in_box    = (ox >= 0) && (ox < OBJECT_WIDTH_X) && (oy >= 0) && (oy < OBJECT_HIGHT_Y);
      if (in_box) begin
         edge_bits[LEFT]   = (ox < EDGE_MARGIN);
         edge_bits[RIGHT]  = (ox >= OBJECT_WIDTH_X - EDGE_MARGIN);
         edge_bits[TOP]    = (oy < EDGE_MARGIN);
         edge_bits[BOTTOM] = (oy >= OBJECT_HIGHT_Y - EDGE_MARGIN);
      end
   end

endmodule

// File: rtl/hit_edge_detect.sv
// Accumulates player/obstacle overlap pixels over a frame and publishes collision and touched edges.
// Define HIT_EDGE_COUNT_EN to add a saturating per-frame overlap pixel count on hitCount.
module hit_edge_detect
   import hit_edge_pkg::*;
#(
   parameter int OBJECT_WIDTH_X = DEFAULT_OBJECT_WIDTH_X,
   parameter int OBJECT_HIGHT_Y = DEFAULT_OBJECT_HIGHT_Y,
   parameter int EDGE_MARGIN    = DEFAULT_EDGE_MARGIN
)(
   input  logic              clk,
   input  logic              resetN,
   hit_edge_detect_if.slave  bus
);

   state_t             state;
   logic signed [10:0] latched_x;
   logic signed [10:0] latched_y;
   logic signed [10:0] corner_x;
   logic signed [10:0] corner_y;
   logic [3:0]         zone_edges;
   logic               overlap;
   logic               stage_hit;
   logic [3:0]         stage_edges;
   logic               acc_hit;
   logic [3:0]         acc_edges;
`ifdef HIT_EDGE_COUNT_EN
   logic [15:0]        acc_count;
`endif

   // The startOfFrame pixel belongs to the new frame, so it is measured against the corner being latched.
   assign corner_x = bus.startOfFrame ? bus.topLeftX : latched_x;
   assign corner_y = bus.startOfFrame ? bus.topLeftY : latched_y;
   assign overlap  = bus.playerDR && bus.obstacleDR && (state == ACCUM_ST);

   edge_zone_classify #(
      .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
      .OBJECT_HIGHT_Y (OBJECT_HIGHT_Y),
      .EDGE_MARGIN    (EDGE_MARGIN)
   ) u_classify (
      .pixel_x   (bus.pixelX),
      .pixel_y   (bus.pixelY),
      .corner_x  (corner_x),
      .corner_y  (corner_y),
      .edge_bits (zone_edges)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state           <= INITIAL_ST;
         latched_x       <= '0;
         latched_y       <= '0;
         stage_hit       <= 1'b0;
         stage_edges     <= 4'b0000;
         acc_hit         <= 1'b0;
         acc_edges       <= 4'b0000;
         bus.collision   <= 1'b0;
         bus.HitEdgeCode <= 4'b0000;
`ifdef HIT_EDGE_COUNT_EN
         acc_count       <= 16'd0;
         bus.hitCount    <= 16'd0;
`endif
      end else begin
         stage_hit   <= overlap;
         stage_edges <= overlap ? zone_edges : 4'b0000;
         if (bus.startOfFrame) begin
            latched_x <= bus.topLeftX;
            latched_y <= bus.topLeftY;
         end
         case (state)
            INITIAL_ST: begin
               state <= WAIT_SOF_ST;
            end
            WAIT_SOF_ST: begin
               if (bus.startOfFrame) begin
                  state <= ACCUM_ST;
               end
            end
            ACCUM_ST: begin
               // The stage still holds the last pixel of the closing frame, so fold it into the result.
               if (bus.startOfFrame) begin
                  bus.collision   <= acc_hit | stage_hit;
                  bus.HitEdgeCode <= acc_edges | stage_edges;
                  acc_hit         <= 1'b0;
                  acc_edges       <= 4'b0000;
`ifdef HIT_EDGE_COUNT_EN
                  bus.hitCount    <= sat_inc(acc_count, stage_hit);
                  acc_count       <= 16'd0;
`endif
               end else begin
                  acc_hit   <= acc_hit | stage_hit;
                  acc_edges <= acc_edges | stage_edges;
`ifdef HIT_EDGE_COUNT_EN
                  acc_count <= sat_inc(acc_count, stage_hit);
`endif
               end
            end
            default: begin
               state <= INITIAL_ST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hit_edge_detect.sv
// Directed-vector bench for hit_edge_detect with hand-computed per-frame results.
// hitCount expectations are checked only when HIT_EDGE_COUNT_EN is defined.
module tb_hit_edge_detect;

   logic               clk;
   logic               resetN;
   logic signed [10:0] corner_x;
   logic signed [10:0] corner_y;
   int                 check_count;
   int                 error_count;

   hit_edge_detect_if bus ();

   hit_edge_detect dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge so the DUT sees them stable at the next rising edge.
   task automatic applyStimulus(input logic sof, input logic [10:0] px, input logic [10:0] py,
                                input logic pdr, input logic odr);
      @(negedge clk);
      bus.startOfFrame = sof;
      bus.pixelX       = px;
      bus.pixelY       = py;
      bus.playerDR     = pdr;
      bus.obstacleDR   = odr;
      bus.topLeftX     = corner_x;
      bus.topLeftY     = corner_y;
   endtask

   task automatic pixel(input logic [10:0] px, input logic [10:0] py);
      applyStimulus(1'b0, px, py, 1'b1, 1'b1);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 11'd0, 11'd0, 1'b0, 1'b0);
   endtask

   task automatic startFrame();
      applyStimulus(1'b1, 11'd0, 11'd0, 1'b0, 1'b0);
   endtask

   task automatic checkFrame(input string tag, input logic col, input logic [3:0] code, input logic [15:0] cnt);
      checkOutput({tag, "_col"}, {15'd0, bus.collision}, {15'd0, col});
      checkOutput({tag, "_code"}, {12'd0, bus.HitEdgeCode}, {12'd0, code});
`ifdef HIT_EDGE_COUNT_EN
      checkOutput({tag, "_cnt"}, bus.hitCount, cnt);
`else
      if (cnt > 16'd1000) $display("[TB] note: unexpected count argument for %s", tag);
`endif
   endtask

   // Close the current frame and look at what it published.
   task automatic closeFrame(input string tag, input logic col, input logic [3:0] code, input logic [15:0] cnt);
      startFrame();
      idle();
      checkFrame(tag, col, code, cnt);
   endtask

   initial begin
      check_count      = 0;
      error_count      = 0;
      corner_x         = 11'sd280;
      corner_y         = 11'sd185;
      resetN           = 1'b0;
      bus.startOfFrame = 1'b0;
      bus.pixelX       = '0;
      bus.pixelY       = '0;
      bus.playerDR     = 1'b0;
      bus.obstacleDR   = 1'b0;
      bus.topLeftX     = corner_x;
      bus.topLeftY     = corner_y;

      repeat (3) idle();
      checkFrame("reset", 1'b0, 4'b0000, 16'd0);
      resetN = 1'b1;
      idle();
      idle();
      pixel(11'd282, 11'd200);
      idle();

      closeFrame("first_sof", 1'b0, 4'b0000, 16'd0);
      pixel(11'd282, 11'd200);
      idle();
      closeFrame("left_only", 1'b1, 4'b1000, 16'd1);

      pixel(11'd343, 11'd248);
      pixel(11'd281, 11'd186);
      idle();
      checkFrame("hold", 1'b1, 4'b1000, 16'd1);
      closeFrame("all_edges", 1'b1, 4'b1111, 16'd2);

      pixel(11'd312, 11'd217);
      idle();
      closeFrame("center", 1'b1, 4'b0000, 16'd1);

      applyStimulus(1'b0, 11'd282, 11'd200, 1'b1, 1'b0);
      applyStimulus(1'b0, 11'd282, 11'd200, 1'b0, 1'b1);
      idle();
      closeFrame("no_overlap", 1'b0, 4'b0000, 16'd0);

      pixel(11'd288, 11'd240);
      pixel(11'd336, 11'd192);
      idle();
      closeFrame("boundary", 1'b1, 4'b0110, 16'd2);

      pixel(11'd344, 11'd200);
      pixel(11'd279, 11'd192);
      idle();
      closeFrame("outside", 1'b1, 4'b0000, 16'd2);

      idle();
      applyStimulus(1'b1, 11'd281, 11'd200, 1'b1, 1'b1);
      idle();
      checkFrame("sof_excluded", 1'b0, 4'b0000, 16'd0);
      idle();
      closeFrame("sof_next", 1'b1, 4'b1000, 16'd1);

      corner_x = -11'sd10;
      corner_y = 11'sd100;
      closeFrame("empty", 1'b0, 4'b0000, 16'd0);
      pixel(11'd0, 11'd130);
      idle();
      closeFrame("neg_corner", 1'b1, 4'b0000, 16'd1);
      pixel(11'd1, 11'd100);
      idle();
      closeFrame("neg_top", 1'b1, 4'b0100, 16'd1);

      pixel(11'd5, 11'd110);
      @(negedge clk);
      resetN = 1'b0;
      #1;
      checkFrame("reset_mid", 1'b0, 4'b0000, 16'd0);
      idle();
      idle();
      resetN = 1'b1;
      repeat (3) idle();
      closeFrame("reset_sof1", 1'b0, 4'b0000, 16'd0);
      pixel(11'd5, 11'd100);
      idle();
      closeFrame("reset_sof2", 1'b1, 4'b0100, 16'd1);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
